ahb_master_fifo: RTL and testbench
==================================

// Module: ahb_master_fifo
// PURPOSE
//  Command/write-data FIFO between the core and ahb_master_port. Stores
//  67-bit entries {HSIZE[2:0], HADDR[31:0], WDATA[31:0]} and presents the
//  head as first-word-fall-through.
//  - Retains up to MAX_BACK already-popped entries.
//  - On RETRY/SPLIT the port pulses tail_back; the read pointer then rewinds
//    by back_length and the lost beats are re-issued.
// PARAMETERS
//  WIDTH     67  entry width {size,addr,data}
//  DEPTH     32  storage entries, power of 2, DEPTH > MAX_BACK
//  AW        5   pointer width, log2(DEPTH)
//  MAX_BACK  16  max popped entries retained for rewind (max back_length)
// PORTS
//  HCLK         in   1      bus clock, all state on rising edge
//  HRESETn      in   1      asynchronous, active-low reset
//  wr_en        in   1      push din (from port fifo_writen)
//  din          in   WIDTH  entry to push
//  rd_en        in   1      pop head (from port fifo_readen)
//  dout         out  WIDTH  head entry, FWFT; 0 when empty
//  empty        out  1      no unread entries
//  full         out  1      unread + retained entries == DEPTH
//  tail_back    in   1      rewind request (RETRY/SPLIT seen by port)
//  back_length  in   5      entries to rewind, 0..MAX_BACK
//  level        out  AW+1   unread entry count
//  rewind_err   out  1      1-cycle pulse: back_length exceeded retained count
// BEHAVIOUR
//  State: wr_ptr, rd_ptr (AW bits, wrap mod DEPTH);
//    level (0..DEPTH); hist = retained popped entries (0..MAX_BACK).
//  Reset (async, HRESETn=0): wr_ptr=rd_ptr=0, level=0, hist=0, empty=1,
//    full=0, dout=0, rewind_err=0. Memory contents are not reset.
//    Reset mid-burst discards all entries.
//  Outputs:
//    - empty = (level==0); full = (level+hist == DEPTH). Both combinational
//      from registers.
//    - dout = empty ? 0 : mem[rd_ptr]. Zero-cycle read latency.
//  Write: wr_en & !full -> mem[wr_ptr]<=din, wr_ptr+1, level+1.
//    wr_en while full is dropped silently; no state change.
//  Pop: rd_en & !empty & !tail_back -> rd_ptr+1, level-1.
//    - hist<MAX_BACK: hist+1.
//    - hist==MAX_BACK: oldest retained slot is freed; hist unchanged.
//    rd_en while empty is ignored.
//  Rewind: tail_back=1 -> n = min(back_length, hist);
//    rd_ptr-=n (mod DEPTH), level+=n, hist-=n.
//    - rd_en in the same cycle is ignored (tail_back has priority).
//    - back_length>hist: clamp to hist, rewind_err=1 for that cycle.
//    - back_length==0: no-op, no error.
//  Simultaneous:
//    - wr+pop: level unchanged; hist updates per pop rule.
//    - wr+rewind: both apply; level += 1+n.
//    - wr when full + pop in the same cycle: write still dropped, because
//      full is evaluated before the edge.
//  Retention release: idle (no pop/rewind) for one cycle with
//    HTRANS-level completion is not visible here. Retained entries are
//    freed only by later pops. level+hist never exceeds DEPTH.
//  Arithmetic: level is AW+1 bits; pointer math is modulo 2^AW.
//    back_length is zero-extended to compare with hist.
// TESTING
//  1 Reset, push A,B,C with no pops -> level=3, dout=A, empty=0; 3 pops -> dout
//    A,B,C in order, then empty=1, dout=0, hist=3.
//  2 Fill 32 pushes with no pops -> full=1 on 32nd edge; 33rd push dropped;
//    pop 16 then push 1 -> full stays 1 (hist=16 holds slots); pop 1 more ->
//    full=0.
//  3 Push 8, pop 5, tail_back with back_length=2 -> rd_ptr back 2,
//    dout = entry#3, level=5, hist=3.
//  4 hist=3, tail_back with back_length=5 -> rewinds 3, rewind_err pulses 1
//    cycle, hist=0; tail_back+rd_en same cycle -> only rewind applied.
//  5 Simultaneous push+pop at level=1 -> level=1, dout=new entry; wr_ptr and
//    rd_ptr wrap past 31 -> ordering preserved over 100 random push/pops
//    vs a scoreboard.
//  6 Assert HRESETn low mid-traffic (level=10) -> asynchronously empty=1,
//    full=0, level=0, dout=0.

Source files
------------

// File: rtl/ahb_master_fifo.sv
// rtl/ahb_master_fifo.sv - FWFT command/write-data FIFO with rewind of popped entries
// Entry layout: {HSIZE[2:0], HADDR[31:0], WDATA[31:0]}.
module ahb_master_fifo #(
    parameter int WIDTH    = 67,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int MAX_BACK = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    input  logic             tail_back,
    input  logic [4:0]       back_length,
    output logic [AW:0]      level,
    output logic             rewind_err
);

    localparam int HW = $clog2(MAX_BACK + 1);
    localparam int CW = (HW > 5) ? HW : 5;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [HW-1:0] hist_q, hist_d;
    logic          rewind_err_q, rewind_err_d;

    logic          wr_fire;
    logic [CW-1:0] bl_w, hist_w, n_w;
    logic [AW+1:0] occupied;

    // Retained (popped but rewindable) slots count against capacity.
    assign occupied = {1'b0, level_q} + (AW+2)'(hist_q);
    assign full     = (occupied == (AW+2)'(DEPTH));
    assign empty    = (level_q == '0);
    assign dout     = empty ? '0 : mem[rd_ptr_q];
    assign level    = level_q;
    assign rewind_err = rewind_err_q;

    assign wr_fire = wr_en & ~full;
    assign bl_w    = CW'(back_length);
    assign hist_w  = CW'(hist_q);
    assign n_w     = (bl_w > hist_w) ? hist_w : bl_w;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        hist_d       = hist_q;
        rewind_err_d = 1'b0;

        // A rewind takes priority over a pop in the same cycle.
        if (tail_back) begin
            rd_ptr_d     = rd_ptr_q - AW'(n_w);
            level_d      = level_q + (AW+1)'(n_w);
            hist_d       = hist_q - HW'(n_w);
            rewind_err_d = (bl_w > hist_w);
        end else if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            level_d  = level_q - (AW+1)'(1);
            if (hist_q != HW'(MAX_BACK)) begin
                hist_d = hist_q + HW'(1);
            end
        end

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            level_d  = level_d + (AW+1)'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            hist_q       <= '0;
            rewind_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            hist_q       <= hist_d;
            rewind_err_q <= rewind_err_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_ahb_master_fifo.sv
// tb/tb_ahb_master_fifo.sv - directed and scoreboarded checks for ahb_master_fifo
module tb_ahb_master_fifo;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        wr_en = 1'b0;
    logic [66:0] din = '0;
    logic        rd_en = 1'b0;
    logic [66:0] dout;
    logic        empty;
    logic        full;
    logic        tail_back = 1'b0;
    logic [4:0]  back_length = '0;
    logic [5:0]  level;
    logic        rewind_err;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_master_fifo dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .tail_back   (tail_back),
        .back_length (back_length),
        .level       (level),
        .rewind_err  (rewind_err)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [66:0] ent(input int i);
        return {3'd2, 32'h1000_0000 + 32'(i) * 32'd4, 32'hA5A5_0000 ^ 32'(i)};
    endfunction

    task automatic cyc(input logic w, input logic [66:0] d, input logic r,
                       input logic t, input logic [4:0] bl);
        wr_en = w; din = d; rd_en = r; tail_back = t; back_length = bl;
        @(posedge HCLK);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; tail_back = 1'b0; back_length = '0;
    endtask

    task automatic do_reset(input bit chk);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        if (chk) begin
            check("rst_empty", 67'(empty), 67'(1));
            check("rst_full", 67'(full), 67'(0));
            check("rst_level", 67'(level), 67'(0));
            check("rst_dout", dout, 67'(0));
            check("rst_err", 67'(rewind_err), 67'(0));
        end
        HRESETn = 1'b1;
    endtask

    logic [66:0] sb[$];
    int          mhist;

    initial begin
        // 1: basic FWFT ordering
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, ent(i), 1'b0, 1'b0, 5'd0);
        check("t1_level", 67'(level), 67'(3));
        check("t1_empty", 67'(empty), 67'(0));
        for (int i = 0; i < 3; i++) begin
            check("t1_dout", dout, ent(i));
            cyc(1'b0, '0, 1'b1, 1'b0, 5'd0);
        end
        check("t1_empty_end", 67'(empty), 67'(1));
        check("t1_dout_end", dout, 67'(0));
        cyc(1'b0, '0, 1'b0, 1'b1, 5'd3);
        check("t1_rew_dout", dout, ent(0));
        check("t1_rew_level", 67'(level), 67'(3));
        check("t1_rew_err", 67'(rewind_err), 67'(0));

        // 2: full with retained entries
        do_reset(1'b0);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, ent(i), 1'b0, 1'b0, 5'd0);
            if (i == 30) check("t2_full31", 67'(full), 67'(0));
        end
        check("t2_full32", 67'(full), 67'(1));
        check("t2_level32", 67'(level), 67'(32));
        cyc(1'b1, ent(99), 1'b0, 1'b0, 5'd0);
        check("t2_drop_level", 67'(level), 67'(32));
        for (int i = 0; i < 16; i++) begin
            check("t2_pop_dout", dout, ent(i));
            cyc(1'b0, '0, 1'b1, 1'b0, 5'd0);
        end
        check("t2_hist_full", 67'(full), 67'(1));
        check("t2_level16", 67'(level), 67'(16));
        cyc(1'b1, ent(98), 1'b0, 1'b0, 5'd0);
        check("t2_drop2_level", 67'(level), 67'(16));
        check("t2_drop2_full", 67'(full), 67'(1));
        check("t2_dout16", dout, ent(16));
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0);
        check("t2_free_full", 67'(full), 67'(0));
        check("t2_level15", 67'(level), 67'(15));
        cyc(1'b1, ent(50), 1'b0, 1'b0, 5'd0);
        check("t2_refull", 67'(full), 67'(1));
        cyc(1'b1, ent(51), 1'b1, 1'b0, 5'd0);
        check("t2_wrpop_full_level", 67'(level), 67'(15));
        check("t2_wrpop_full_full", 67'(full), 67'(0));
        for (int i = 0; i < 15; i++) begin
            check("t2_drain", dout, (i < 14) ? ent(18 + i) : ent(50));
            cyc(1'b0, '0, 1'b1, 1'b0, 5'd0);
        end
        check("t2_drain_empty", 67'(empty), 67'(1));

        // 3/4: rewind, clamp, priority
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, ent(i), 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0, 5'd0);
        check("t3_dout5", dout, ent(5));
        cyc(1'b0, '0, 1'b0, 1'b1, 5'd2);
        check("t3_rew_dout", dout, ent(3));
        check("t3_rew_level", 67'(level), 67'(5));
        check("t3_rew_err", 67'(rewind_err), 67'(0));
        cyc(1'b0, '0, 1'b0, 1'b1, 5'd5);
        check("t4_clamp_dout", dout, ent(0));
        check("t4_clamp_level", 67'(level), 67'(8));
        check("t4_err_pulse", 67'(rewind_err), 67'(1));
        cyc(1'b0, '0, 1'b0, 1'b0, 5'd0);
        check("t4_err_clear", 67'(rewind_err), 67'(0));
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0);
        check("t4_dout2", dout, ent(2));
        cyc(1'b0, '0, 1'b1, 1'b1, 5'd1);
        check("t4_prio_dout", dout, ent(1));
        check("t4_prio_level", 67'(level), 67'(7));
        cyc(1'b0, '0, 1'b1, 1'b1, 5'd0);
        check("t4_zero_dout", dout, ent(1));
        check("t4_zero_level", 67'(level), 67'(7));
        check("t4_zero_err", 67'(rewind_err), 67'(0));
        cyc(1'b1, ent(60), 1'b0, 1'b1, 5'd1);
        check("t4_wrrew_level", 67'(level), 67'(9));
        check("t4_wrrew_dout", dout, ent(0));

        // 5: simultaneous push/pop, then random traffic against a scoreboard
        do_reset(1'b0);
        cyc(1'b1, ent(70), 1'b0, 1'b0, 5'd0);
        cyc(1'b1, ent(71), 1'b1, 1'b0, 5'd0);
        check("t5_wrpop_level", 67'(level), 67'(1));
        check("t5_wrpop_dout", dout, ent(71));
        sb.delete();
        sb.push_back(ent(71));
        mhist = 1;
        for (int c = 0; c < 100; c++) begin
            logic        w, r, mfull, pop_ok;
            logic [66:0] d;
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 50);
            d = {3'($urandom), $urandom, $urandom};
            check("t5_dout", dout, (sb.size() > 0) ? sb[0] : 67'(0));
            check("t5_level", 67'(level), 67'(sb.size()));
            mfull = ((sb.size() + mhist) == 32);
            check("t5_full", 67'(full), 67'(mfull));
            pop_ok = r && (sb.size() > 0);
            cyc(w, d, r, 1'b0, 5'd0);
            if (pop_ok) begin
                void'(sb.pop_front());
                if (mhist < 16) mhist++;
            end
            if (w && !mfull) sb.push_back(d);
        end

        // 6: asynchronous reset mid-traffic
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, ent(i), 1'b0, 1'b0, 5'd0);
        check("t6_level_pre", 67'(level), 67'(10));
        #3;
        HRESETn = 1'b0;
        #1;
        check("t6_empty", 67'(empty), 67'(1));
        check("t6_full", 67'(full), 67'(0));
        check("t6_level", 67'(level), 67'(0));
        check("t6_dout", dout, 67'(0));
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
